// File: rtl/ram_wb_arb2.sv
// Two-master Wishbone B3 arbiter for the on-chip RAM slave: round-robin grant held
// for a whole bus cycle, plus a per-beat watchdog that turns a hung access into err.
module ram_wb_arb2 #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int timeout_cycles = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,

  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,

  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,

  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  localparam bit       WDOG_EN = (timeout_cycles != 0);
  localparam logic [7:0] TMO   = 8'(timeout_cycles);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] wdog_q, wdog_d;

  logic req0, req1, term, gnt0, gnt1, expire;
  logic cur_cyc, oth_req;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign term = s_ack_i | s_err_i | s_rty_i;
  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Slave-side mux and termination routing; everything is zero outside a grant.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
    end
  end

  // A termination in the expiry cycle wins, so expire requires no ack/err/rty.
  assign expire = WDOG_EN && (gnt0 || gnt1) && s_stb_o && !term && (wdog_q == TMO);

  assign m0_dat_o = (gnt0 || gnt1) ? s_dat_i : '0;
  assign m1_dat_o = (gnt0 || gnt1) ? s_dat_i : '0;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | expire);
  assign m0_rty_o = gnt0 & s_rty_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | expire);
  assign m1_rty_o = gnt1 & s_rty_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = '0;
    cur_cyc = last_q ? m1_cyc_i : m0_cyc_i;
    oth_req = 1'b0;
    if (gnt0) begin
      cur_cyc = m0_cyc_i;
      oth_req = req1;
    end else if (gnt1) begin
      cur_cyc = m1_cyc_i;
      oth_req = req0;
    end
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (expire) begin
          state_d = ABORT;
        end else if (!cur_cyc) begin
          if (oth_req) begin
            state_d = gnt0 ? GNT1 : GNT0;
            last_d  = gnt0;
          end else begin
            state_d = IDLE;
          end
        end else if (WDOG_EN && s_stb_o && !term) begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ABORT: begin
        // last_q still names the aborted master; wait for it to end its cycle.
        if (!cur_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_ram_wb_arb2.sv
// Scoreboard bench for ram_wb_arb2: masters push expected beats, a negedge monitor
// pops and compares them whenever a master sees ack.
module tb_ram_wb_arb2;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic        ack_en;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Zero-wait RAM model: read data is the inverted address.
  assign s_ack_i = s_cyc_o & s_stb_o & ack_en;
  assign s_err_i = 1'b0;
  assign s_rty_i = 1'b0;
  assign s_dat_i = ~s_adr_o;

  ram_wb_arb2 #(.dw(32), .aw(32), .timeout_cycles(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti),
    .m0_bte_i(m0_bte), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti),
    .m1_bte_i(m1_bte), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit n, input logic cyc, input logic [31:0] adr,
                       input logic we, input logic [2:0] cti, input bit push);
    exp_t e;
    e.adr  = adr;
    e.we   = we;
    e.wdat = adr ^ 32'hC3C3_0000;
    e.cti  = cti;
    e.bte  = (cti == 3'b000) ? 2'b00 : 2'b01;
    if (!n) begin
      m0_cyc = cyc; m0_stb = cyc; m0_adr = adr; m0_we = we;
      m0_dat = e.wdat; m0_cti = cti; m0_bte = e.bte; m0_sel = 4'hF;
      if (cyc && push) q0.push_back(e);
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_adr = adr; m1_we = we;
      m1_dat = e.wdat; m1_cti = cti; m1_bte = e.bte; m1_sel = 4'hF;
      if (cyc && push) q1.push_back(e);
    end
  endtask

  task automatic sb_pop(input bit n);
    exp_t e;
    logic [31:0] rdat;
    if ((n ? q1.size() : q0.size()) == 0) begin
      chk($sformatf("m%0d_unexpected_ack", n), 32'd1, 32'd0);
    end else begin
      e    = n ? q1.pop_front() : q0.pop_front();
      rdat = n ? m1_dat_o : m0_dat_o;
      chk($sformatf("m%0d_adr", n), s_adr_o, e.adr);
      chk($sformatf("m%0d_we", n), 32'(s_we_o), 32'(e.we));
      chk($sformatf("m%0d_cti", n), 32'(s_cti_o), 32'(e.cti));
      chk($sformatf("m%0d_bte", n), 32'(s_bte_o), 32'(e.bte));
      chk($sformatf("m%0d_sel", n), 32'(s_sel_o), 32'hF);
      if (e.we) chk($sformatf("m%0d_wdat", n), s_dat_o, e.wdat);
      else      chk($sformatf("m%0d_rdat", n), rdat, ~e.adr);
    end
  endtask

  always @(negedge clk) begin
    if (m0_ack_o) sb_pop(1'b0);
    if (m1_ack_o) sb_pop(1'b1);
  end

  task automatic m_beat(input bit n, input logic [31:0] adr, input logic [2:0] cti,
                        input int budget);
    bit   got;
    exp_t dummy;
    drive(n, 1'b1, adr, 1'b0, cti, 1'b1);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = n ? m1_ack_o : m0_ack_o;
    end
    chk($sformatf("m%0d_beat_ack_%h", n, adr), 32'(got), 32'd1);
    if (!got) dummy = n ? q1.pop_back() : q0.pop_back();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit n, input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = n ? m1_ack_o : m0_ack_o;
    end
    chk(tag, 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n  = 1'b0;
    ack_en = 1'b1;
    // Both masters request while reset is held: outputs must stay zero.
    drive(1'b0, 1'b1, 32'h40, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b1, 32'h80, 1'b1, 3'b000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_adr", s_adr_o, 32'd0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack_o), 32'd0);
    chk("rst_m0_dat", m0_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First tie after reset goes to m0; m1 gets the bus right after m0 releases.
    @(negedge clk);
    chk("tie1_m0_ack", 32'(m0_ack_o), 32'd1);
    chk("tie1_m1_ack", 32'(m1_ack_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    chk("hand_rel_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("hand_rel_m1_ack", 32'(m1_ack_o), 32'd0);
    @(negedge clk);
    chk("hand_m1_ack", 32'(m1_ack_o), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h44, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b1, 32'h84, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("tie2_m0_ack", 32'(m0_ack_o), 32'd1);
    chk("tie2_m1_ack", 32'(m1_ack_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    wait_ack(1'b1, 4, "tie2_m1_follow_ack");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;

    // Single classic read from m0.
    drive(1'b0, 1'b1, 32'h100, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    chk("single_s_cyc_arb", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    chk("single_s_cyc", 32'(s_cyc_o), 32'd1);
    chk("single_m0_ack", 32'(m0_ack_o), 32'd1);
    chk("single_m1_ack", 32'(m1_ack_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;

    // m0 wrap-4 burst; m1 requests during beat 2 and must wait for the whole burst.
    fork
      begin
        m_beat(1'b0, 32'h208, 3'b010, 3);
        m_beat(1'b0, 32'h20C, 3'b010, 1);
        m_beat(1'b0, 32'h200, 3'b010, 1);
        m_beat(1'b0, 32'h204, 3'b111, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        m_beat(1'b1, 32'h300, 3'b000, 20);
        chk("burst_m0_done_first", 32'(q0.size()), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
      end
    join
    @(posedge clk); #1;

    // Watchdog: slave never acks m1; err on the 5th strobed cycle, then abort.
    ack_en = 1'b0;
    drive(1'b1, 1'b1, 32'h400, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    chk("wd_idle_s_cyc", 32'(s_cyc_o), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("wd_m1_err_c%0d", i), 32'(m1_err_o), (i == 5) ? 32'd1 : 32'd0);
      chk($sformatf("wd_s_cyc_c%0d", i), 32'(s_cyc_o), 32'd1);
    end
    @(negedge clk);
    chk("wd_abort_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("wd_abort_m1_err", 32'(m1_err_o), 32'd0);
    @(posedge clk); #1;
    ack_en = 1'b1;
    drive(1'b0, 1'b1, 32'h500, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wd_hold_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("wd_hold_m0_ack", 32'(m0_ack_o), 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    chk("wd_exit_m0_ack0", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    chk("wd_exit_m0_ack1", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    chk("wd_exit_m0_ack2", 32'(m0_ack_o), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;

    // Watchdog boundary: ack lands exactly when the count reaches the limit.
    ack_en = 1'b0;
    drive(1'b0, 1'b1, 32'h600, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("wdb_m0_err_c%0d", i), 32'(m0_err_o), 32'd0);
    end
    @(posedge clk); #1;
    ack_en = 1'b1;
    @(negedge clk);
    chk("wdb_m0_ack", 32'(m0_ack_o), 32'd1);
    chk("wdb_m0_err", 32'(m0_err_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk); #1;

    // Async reset in the middle of an m1 burst.
    drive(1'b1, 1'b1, 32'h700, 1'b0, 3'b010, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rb_m1_ack", 32'(m1_ack_o), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h704, 1'b0, 3'b010, 1'b0);
    chk("rb_pre_s_cyc", 32'(s_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rb_s_stb", 32'(s_stb_o), 32'd0);
    chk("rb_s_adr", s_adr_o, 32'd0);
    chk("rb_m1_ack_low", 32'(m1_ack_o), 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h800, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b1, 32'h900, 1'b1, 3'b000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rtie_m0_ack", 32'(m0_ack_o), 32'd1);
    chk("rtie_m1_ack", 32'(m1_ack_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    wait_ack(1'b1, 4, "rtie_m1_follow_ack");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
